vga_term: RTL

Character-stream terminal front end for the VGA text console: accepts one character per handshake, tracks the cursor, interprets a small set of control codes and drives the write port of the character memory (`vga_cmem`). It sits between the CPU's console MMIO register and `vga_cmem`. It also performs row and screen clears by sequencing blank writes, so the CPU never addresses cells directly.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_term.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, state enum and write-port payload for the VGA
// text console front end (vga_term). No ports.
package vga_pkg;

  localparam int unsigned DEF_COLS = 70;
  localparam int unsigned DEF_ROWS = 30;

  localparam int unsigned ROW_W   = 5;
  localparam int unsigned COL_W   = 7;
  localparam int unsigned ASCII_W = 8;
  localparam int unsigned COLOR_W = 3;

  localparam logic [ASCII_W-1:0] CH_BS    = 8'h08;
  localparam logic [ASCII_W-1:0] CH_LF    = 8'h0A;
  localparam logic [ASCII_W-1:0] CH_FF    = 8'h0C;
  localparam logic [ASCII_W-1:0] CH_CR    = 8'h0D;
  localparam logic [ASCII_W-1:0] CH_SPACE = 8'h20;
  localparam logic [ASCII_W-1:0] CH_TILDE = 8'h7E;

  localparam logic [COLOR_W-1:0] RST_FG = 3'd7;
  localparam logic [COLOR_W-1:0] RST_BG = 3'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } term_state_t;

  // One write into the character memory.
  typedef struct packed {
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [ASCII_W-1:0] ascii;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
  } cmem_wr_t;

endpackage

// File: rtl/vga_term.sv
// vga_term: character-stream terminal front end. Accepts one character per
// valid/ready handshake, tracks the cursor, handles BS/LF/FF/CR and drives the
// vga_cmem write port, sequencing blank writes for row and screen clears.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        character handshake
//   in_ascii/in_fg/in_bg     character code and its colours
//   we, wr_addr, wc_addr     registered write strobe and cell address
//   w_ascii, w_fg/bg_color   registered write data
//   cur_row, cur_col         cursor position for rendering
module vga_term
  import vga_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ASCII_W-1:0] in_ascii,
  input  logic [COLOR_W-1:0] in_fg,
  input  logic [COLOR_W-1:0] in_bg,
  output logic               we,
  output logic [ROW_W-1:0]   wr_addr,
  output logic [COL_W-1:0]   wc_addr,
  output logic [ASCII_W-1:0] w_ascii,
  output logic [COLOR_W-1:0] w_fg_color,
  output logic [COLOR_W-1:0] w_bg_color,
  output logic [ROW_W-1:0]   cur_row,
  output logic [COL_W-1:0]   cur_col
);

  // Counters are one bit wider than the addresses so they can reach COLS/ROWS
  // as the "done" value.
  localparam int unsigned CCNT_W = COL_W + 1;
  localparam int unsigned RCNT_W = ROW_W + 1;

  term_state_t        state_q, state_d;
  cmem_wr_t           wr_q, wr_d;
  logic               we_q, we_d;
  logic               ready_q, ready_d;
  logic [ROW_W-1:0]   cur_row_q, cur_row_d;
  logic [COL_W-1:0]   cur_col_q, cur_col_d;
  logic [CCNT_W-1:0]  ccnt_q, ccnt_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic [COLOR_W-1:0] clr_fg_q, clr_fg_d;
  logic [COLOR_W-1:0] clr_bg_q, clr_bg_d;
  logic               xfer;
  logic               printable;
  logic [ROW_W-1:0]   row_adv;

  assign xfer      = in_valid && ready_q;
  assign printable = (in_ascii >= CH_SPACE) && (in_ascii <= CH_TILDE);
  assign row_adv   = (cur_row_q == ROW_W'(ROWS - 1)) ? '0 : cur_row_q + ROW_W'(1);

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    we_d      = 1'b0;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    ccnt_d    = ccnt_q;
    rcnt_d    = rcnt_q;
    clr_fg_d  = clr_fg_q;
    clr_bg_d  = clr_bg_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (printable) begin
            we_d = 1'b1;
            wr_d = '{row: cur_row_q, col: cur_col_q, ascii: in_ascii, fg: in_fg, bg: in_bg};
            if (cur_col_q == COL_W'(COLS - 1)) begin
              // Wrap: the character write goes out first, the clear follows.
              cur_col_d = '0;
              cur_row_d = row_adv;
              clr_fg_d  = in_fg;
              clr_bg_d  = in_bg;
              ccnt_d    = '0;
              state_d   = CLR_ROW;
            end else begin
              cur_col_d = cur_col_q + COL_W'(1);
            end
          end else begin
            case (in_ascii)
              CH_LF: begin
                // Column 0 of the new row is written right away.
                cur_col_d = '0;
                cur_row_d = row_adv;
                clr_fg_d  = in_fg;
                clr_bg_d  = in_bg;
                we_d      = 1'b1;
                wr_d      = '{row: row_adv, col: '0, ascii: CH_SPACE, fg: in_fg, bg: in_bg};
                ccnt_d    = CCNT_W'(1);
                state_d   = CLR_ROW;
              end
              CH_CR: cur_col_d = '0;
              CH_BS: begin
                if (cur_col_q != '0) begin
                  cur_col_d = cur_col_q - COL_W'(1);
                  we_d      = 1'b1;
                  wr_d      = '{row: cur_row_q, col: cur_col_q - COL_W'(1), ascii: CH_SPACE,
                                fg: in_fg, bg: in_bg};
                end
              end
              CH_FF: begin
                cur_row_d = '0;
                cur_col_d = '0;
                clr_fg_d  = in_fg;
                clr_bg_d  = in_bg;
                ccnt_d    = '0;
                rcnt_d    = '0;
                state_d   = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end

      // Blank the cursor row; the extra cycle at ccnt==COLS lets the last
      // write be presented before in_ready rises.
      CLR_ROW: begin
        if (ccnt_q == CCNT_W'(COLS)) begin
          state_d = IDLE;
        end else begin
          we_d   = 1'b1;
          wr_d   = '{row: cur_row_q, col: COL_W'(ccnt_q), ascii: CH_SPACE,
                     fg: clr_fg_q, bg: clr_bg_q};
          ccnt_d = ccnt_q + CCNT_W'(1);
        end
      end

      // Row-major blank of the whole screen.
      CLR_ALL: begin
        if (rcnt_q == RCNT_W'(ROWS)) begin
          state_d = IDLE;
        end else begin
          we_d = 1'b1;
          wr_d = '{row: ROW_W'(rcnt_q), col: COL_W'(ccnt_q), ascii: CH_SPACE,
                   fg: clr_fg_q, bg: clr_bg_q};
          if (ccnt_q == CCNT_W'(COLS - 1)) begin
            ccnt_d = '0;
            rcnt_d = rcnt_q + RCNT_W'(1);
          end else begin
            ccnt_d = ccnt_q + CCNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLR_ALL;
      wr_q      <= '{row: '0, col: '0, ascii: CH_SPACE, fg: RST_FG, bg: RST_BG};
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      ccnt_q    <= '0;
      rcnt_q    <= '0;
      clr_fg_q  <= RST_FG;
      clr_bg_q  <= RST_BG;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      ccnt_q    <= ccnt_d;
      rcnt_q    <= rcnt_d;
      clr_fg_q  <= clr_fg_d;
      clr_bg_q  <= clr_bg_d;
    end
  end

  assign in_ready   = ready_q;
  assign we         = we_q;
  assign wr_addr    = wr_q.row;
  assign wc_addr    = wr_q.col;
  assign w_ascii    = wr_q.ascii;
  assign w_fg_color = wr_q.fg;
  assign w_bg_color = wr_q.bg;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;

endmodule
